// File: rtl/id_stage_if.sv
// Decode-stage bus: IF/ID buffer contents, hazard inputs, write-back port
// and the ID/EX buffer. master drives the decode inputs, slave is the stage.
interface id_stage_if;
  logic        instr_valid_ip;
  logic [31:0] instr_data_ip;
  logic [31:0] instr_pc_addr_ip;
  logic        flush_ip;
  logic        ex_mem_read_ip;
  logic [4:0]  ex_rd_ip;
  logic        wb_en_ip;
  logic [4:0]  wb_rd_ip;
  logic [31:0] wb_data_ip;

  // pc_mux_op: 0=NEXTPC, 1=ALU_RESULT, 2=ALU_RESULT_JALR, 3=OFFSET
  logic [1:0]  pc_mux_op;
  logic        stall_op;
  logic        id_valid_op;
  logic [31:0] id_pc_op;
  logic [31:0] rs1_data_op;
  logic [31:0] rs2_data_op;
  logic [31:0] imm_op;
  logic [4:0]  rd_op;
  logic [3:0]  alu_op;
  logic        alu_src_a_op;
  logic        alu_src_b_op;
  logic [2:0]  funct3_op;
  logic        mem_read_op;
  logic        mem_write_op;
  logic        reg_write_op;
  logic [1:0]  wb_sel_op;
  logic        branch_op;
  logic        jump_op;
  logic        illegal_op;

  modport master (
    output instr_valid_ip, instr_data_ip, instr_pc_addr_ip, flush_ip,
           ex_mem_read_ip, ex_rd_ip, wb_en_ip, wb_rd_ip, wb_data_ip,
    input  pc_mux_op, stall_op, id_valid_op, id_pc_op, rs1_data_op,
           rs2_data_op, imm_op, rd_op, alu_op, alu_src_a_op, alu_src_b_op,
           funct3_op, mem_read_op, mem_write_op, reg_write_op, wb_sel_op,
           branch_op, jump_op, illegal_op
  );

  modport slave (
    input  instr_valid_ip, instr_data_ip, instr_pc_addr_ip, flush_ip,
           ex_mem_read_ip, ex_rd_ip, wb_en_ip, wb_rd_ip, wb_data_ip,
    output pc_mux_op, stall_op, id_valid_op, id_pc_op, rs1_data_op,
           rs2_data_op, imm_op, rd_op, alu_op, alu_src_a_op, alu_src_b_op,
           funct3_op, mem_read_op, mem_write_op, reg_write_op, wb_sel_op,
           branch_op, jump_op, illegal_op
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: instruction decode, register file with write-through
// bypass, load-use stall detection and the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic      clock,
  input  logic      reset,
  id_stage_if.slave bus
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F,
                         OP_JALR = 7'h67, OP_BRANCH = 7'h63, OP_LOAD = 7'h03,
                         OP_STORE = 7'h23, OP_IMM = 7'h13, OP_OP = 7'h33,
                         OP_FENCE = 7'h0F, OP_SYSTEM = 7'h73;
  localparam logic [1:0] PC_NEXT = 2'd0, PC_ALU = 2'd1, PC_JALR = 2'd2, PC_OFFSET = 2'd3;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_COPYB = 4'b1111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            src_a;
    logic            src_b;
    logic [2:0]      funct3;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            branch;
    logic            jump;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] regs_q [NREGS];
  logic            stall_q;
  idex_t           idex_q, idex_d, dec;

  logic [31:0] ins;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_val, rs2_val;
  logic        illegal, uses_rs1, uses_rs2, hazard, stall;
  logic [1:0]  pc_sel;

  assign ins    = bus.instr_data_ip;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];

  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // A write landing this edge is forwarded so the ID/EX entry sees it.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0)
      rs1_val = (bus.wb_en_ip && bus.wb_rd_ip == rs1) ? bus.wb_data_ip : regs_q[rs1];
    if (rs2 != 5'd0)
      rs2_val = (bus.wb_en_ip && bus.wb_rd_ip == rs2) ? bus.wb_data_ip : regs_q[rs2];
  end

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = bus.instr_pc_addr_ip;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    dec.funct3   = funct3;
    dec.alu_op   = ALU_ADD;
    illegal      = 1'b0;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    pc_sel       = PC_NEXT;
    unique case (opcode)
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.src_b = 1'b1; dec.alu_op = ALU_COPYB;
        dec.imm = imm_u; uses_rs1 = 1'b0;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1; dec.src_a = 1'b1; dec.src_b = 1'b1;
        dec.imm = imm_u; uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.src_a = 1'b1; dec.src_b = 1'b1;
        dec.wb_sel = 2'd2; dec.imm = imm_j; uses_rs1 = 1'b0; pc_sel = PC_ALU;
      end
      OP_JALR: begin
        illegal = (funct3 != 3'b000);
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.src_b = 1'b1;
        dec.wb_sel = 2'd2; dec.imm = imm_i; pc_sel = PC_JALR;
      end
      OP_BRANCH: begin
        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
        dec.branch = 1'b1; dec.alu_op = ALU_SUB; dec.imm = imm_b;
        uses_rs2 = 1'b1; pc_sel = PC_OFFSET;
      end
      OP_LOAD: begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.src_b = 1'b1;
        dec.wb_sel = 2'd1; dec.imm = imm_i;
      end
      OP_STORE: begin
        illegal = funct3[2] || (funct3 == 3'b011);
        dec.mem_write = 1'b1; dec.src_b = 1'b1; dec.imm = imm_s; uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        // Shift-immediates reuse the funct7 slot, so only SLLI/SRLI/SRAI codes are legal.
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
        dec.reg_write = 1'b1; dec.src_b = 1'b1; dec.imm = imm_i;
        dec.alu_op = {(funct3 == 3'b101) && funct7[5], funct3};
      end
      OP_OP: begin
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        dec.reg_write = 1'b1; dec.alu_op = {funct7[5], funct3}; uses_rs2 = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.imm = '0; dec.alu_op = '0; dec.src_a = 1'b0; dec.src_b = 1'b0;
      dec.mem_read = 1'b0; dec.mem_write = 1'b0; dec.reg_write = 1'b0;
      dec.wb_sel = 2'd0; dec.branch = 1'b0; dec.jump = 1'b0; dec.illegal = 1'b1;
      pc_sel = PC_NEXT;
    end
    dec.rd = dec.reg_write ? ins[11:7] : 5'd0;
  end

  assign hazard = bus.ex_mem_read_ip && (bus.ex_rd_ip != 5'd0) &&
                  ((uses_rs1 && bus.ex_rd_ip == rs1) || (uses_rs2 && bus.ex_rd_ip == rs2));
  // The stalled cycle bubbles EX, so a hazard seen right after a stall is the same one.
  assign stall  = reset && bus.instr_valid_ip && !bus.flush_ip && hazard && !stall_q;

  assign bus.stall_op  = stall;
  assign bus.pc_mux_op = (reset && bus.instr_valid_ip) ? pc_sel : PC_NEXT;

  always_comb begin
    idex_d = dec;
    if (!bus.instr_valid_ip || bus.flush_ip || stall)
      idex_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      stall_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      stall_q <= stall;
      if (bus.wb_en_ip && bus.wb_rd_ip != 5'd0)
        regs_q[bus.wb_rd_ip] <= bus.wb_data_ip;
      idex_q <= idex_d;
    end
  end

  assign bus.id_valid_op  = idex_q.valid;
  assign bus.id_pc_op     = idex_q.pc;
  assign bus.rs1_data_op  = idex_q.rs1_data;
  assign bus.rs2_data_op  = idex_q.rs2_data;
  assign bus.imm_op       = idex_q.imm;
  assign bus.rd_op        = idex_q.rd;
  assign bus.alu_op       = idex_q.alu_op;
  assign bus.alu_src_a_op = idex_q.src_a;
  assign bus.alu_src_b_op = idex_q.src_b;
  assign bus.funct3_op    = idex_q.funct3;
  assign bus.mem_read_op  = idex_q.mem_read;
  assign bus.mem_write_op = idex_q.mem_write;
  assign bus.reg_write_op = idex_q.reg_write;
  assign bus.wb_sel_op    = idex_q.wb_sel;
  assign bus.branch_op    = idex_q.branch;
  assign bus.jump_op      = idex_q.jump;
  assign bus.illegal_op   = idex_q.illegal;
endmodule
